sram_fill_check_master: RTL and testbench



---
 rtl/sram_fill_check_master_if.sv | 35 +++
 rtl/sram_fill_check_master.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_fill_check_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_fill_check_master_if.sv
// ---------------------------------------------------------------------------
// sram_fill_check_master_if
//   Avalon-MM bus between the fill/check initiator and the single-port SRAM
//   slave (word addressed, read latency 1, no waitrequest).
//
//   address     word address driven by the initiator
//   byteenable  all lanes enabled whenever chipselect is high
//   chipselect  high on every bus cycle, read or write
//   write       high on write cycles only
//   writedata   write data
//   clken       slave clock enable
//   readdata    slave read data, valid one cycle after a read cycle
// ---------------------------------------------------------------------------
interface sram_fill_check_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/sram_fill_check_master.sv
// ---------------------------------------------------------------------------
// sram_fill_check_master
//   Memory-test initiator for the on-chip SRAM. On start it fills a wrapping
//   address window with a Galois LFSR pattern and/or reads it back, comparing
//   every word against the regenerated pattern. Results are held on status
//   outputs until the next accepted start.
//
//   clk               sole clock
//   rst               asynchronous active-high reset, returns to IDLE
//   start_i           single-cycle request, sampled only in IDLE
//   mode_i            00 fill+check, 01 fill, 10 check, 11 reserved
//   base_addr_i       first word address of the window
//   word_count_i      window length in words (clamped to memory depth)
//   seed_i            LFSR seed (0 is replaced by 1)
//   busy_o            operation in progress
//   done_o            one-cycle pulse at the end of an operation
//   pass_o            last operation finished with no mismatches
//   err_count_o       saturating mismatch count
//   first_err_addr_o  address of the first mismatch
//   first_err_data_o  data read at the first mismatch
//   m_bus             Avalon-MM master port to the SRAM
// ---------------------------------------------------------------------------
module sram_fill_check_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [ADDR_W:0]       word_count_i,
    input  logic [DATA_W-1:0]     seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_W:0]       err_count_o,
    output logic [ADDR_W-1:0]     first_err_addr_o,
    output logic [DATA_W-1:0]     first_err_data_o,
    sram_fill_check_master_if.master m_bus
);

    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] TAPS  = DATA_W'(32'h0040_0007);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_DRAIN,
        S_FINISH
    } state_t;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], 1'b0} ^ (v[DATA_W-1] ? TAPS : '0);
    endfunction

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (&v) ? v : v + (ADDR_W+1)'(1);
    endfunction

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   seed_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   lfsr_q;
    logic                cs_q;
    logic                wr_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [ADDR_W:0]     err_q;
    logic [ADDR_W-1:0]   ferr_addr_q;
    logic [DATA_W-1:0]   ferr_data_q;

    // Compare stage: address/expected word of the read issued one cycle ago.
    logic                cmp_vld_p1_q;
    logic [ADDR_W-1:0]   cmp_addr_p1_q;
    logic [DATA_W-1:0]   cmp_exp_p1_q;

    logic [ADDR_W:0]     wc_clamp_d;
    logic [DATA_W-1:0]   seed_eff_d;
    logic                last_d;
    logic                mismatch_d;
    logic [ADDR_W:0]     err_nxt_d;

    assign wc_clamp_d = (word_count_i > DEPTH) ? DEPTH : word_count_i;
    assign seed_eff_d = (seed_i == '0) ? DATA_W'(1) : seed_i;
    assign last_d     = (idx_q + (ADDR_W+1)'(1)) == count_q;
    assign mismatch_d = cmp_vld_p1_q && (m_bus.readdata != cmp_exp_p1_q);
    // Count including the compare landing this cycle, so the verdict taken
    // on the DRAIN edge already sees the last word.
    assign err_nxt_d  = mismatch_d ? sat_inc(err_q) : err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 2'b00;
            base_q       <= '0;
            seed_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            lfsr_q       <= '0;
            cs_q         <= 1'b0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            ferr_addr_q  <= '0;
            ferr_data_q  <= '0;
            cmp_vld_p1_q <= 1'b0;
        end else begin
            cmp_vld_p1_q <= (state_q == S_CHECK);
            done_q       <= 1'b0;

            if (mismatch_d) begin
                err_q <= err_nxt_d;
                if (err_q == '0) begin
                    ferr_addr_q <= cmp_addr_p1_q;
                    ferr_data_q <= m_bus.readdata;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q      <= mode_i;
                        base_q      <= base_addr_i;
                        seed_q      <= seed_eff_d;
                        lfsr_q      <= seed_eff_d;
                        addr_q      <= base_addr_i;
                        idx_q       <= '0;
                        count_q     <= wc_clamp_d;
                        err_q       <= '0;
                        ferr_addr_q <= '0;
                        ferr_data_q <= '0;
                        pass_q      <= 1'b0;
                        if (mode_i == 2'b11 || wc_clamp_d == '0) begin
                            // Nothing to do: report immediately, bus stays idle.
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            pass_q  <= (mode_i != 2'b11);
                        end else begin
                            state_q <= (mode_i == 2'b10) ? S_CHECK : S_FILL;
                            busy_q  <= 1'b1;
                            cs_q    <= 1'b1;
                            wr_q    <= (mode_i != 2'b10);
                        end
                    end
                end
                S_FILL: begin
                    if (last_d) begin
                        if (mode_q == 2'b00) begin
                            // Back-to-back turnaround into the read pass.
                            state_q <= S_CHECK;
                            wr_q    <= 1'b0;
                            lfsr_q  <= seed_q;
                            addr_q  <= base_q;
                            idx_q   <= '0;
                        end else begin
                            state_q <= S_FINISH;
                            cs_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_nxt_d == '0);
                        end
                    end else begin
                        idx_q  <= idx_q + (ADDR_W+1)'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                        lfsr_q <= lfsr_step(lfsr_q);
                    end
                end
                S_CHECK: begin
                    if (last_d) begin
                        state_q <= S_DRAIN;
                        cs_q    <= 1'b0;
                    end else begin
                        idx_q  <= idx_q + (ADDR_W+1)'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                        lfsr_q <= lfsr_step(lfsr_q);
                    end
                end
                S_DRAIN: begin
                    state_q <= S_FINISH;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_nxt_d == '0);
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ---- stage p1: capture the read just issued for compare next cycle ----
    always_ff @(posedge clk) begin
        cmp_addr_p1_q <= addr_q;
        cmp_exp_p1_q  <= lfsr_q;
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_addr_q;
    assign first_err_data_o = ferr_data_q;

    assign m_bus.address    = addr_q;
    assign m_bus.byteenable = {4{cs_q}};
    assign m_bus.chipselect = cs_q;
    assign m_bus.write      = wr_q;
    assign m_bus.writedata  = lfsr_q;
    assign m_bus.clken      = 1'b1;

endmodule

// File: tb/tb_sram_fill_check_master.sv
// ---------------------------------------------------------------------------
// tb_sram_fill_check_master
//   Bench for sram_fill_check_master with an SRAM slave model, a bus monitor
//   and a reference model computing expected bus traffic and results from
//   the pattern definition.
// ---------------------------------------------------------------------------
module tb_sram_fill_check_master;

    localparam int DEPTH = 1024;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [9:0]  base_i;
    logic [10:0] wc_i;
    logic [31:0] seed_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [10:0] err_o;
    logic [9:0]  ferr_addr_o;
    logic [31:0] ferr_data_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_fill_check_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    sram_fill_check_master #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .mode_i           (mode_i),
        .base_addr_i      (base_i),
        .word_count_i     (wc_i),
        .seed_i           (seed_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .err_count_o      (err_o),
        .first_err_addr_o (ferr_addr_o),
        .first_err_data_o (ferr_data_o),
        .m_bus            (bus)
    );

    // SRAM slave model, bus monitor and done counter
    logic [31:0] mem [DEPTH];
    bit          flip [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    cyc_t        log_q [$];
    int          done_cnt  = 0;
    int          proto_bad = 0;
    int          last_log0 = 0;

    function automatic cyc_t mk(input logic wr, input logic [9:0] a, input logic [31:0] d);
        cyc_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] p);
        return (p << 1) ^ (p[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    always @(posedge clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (bus.chipselect) begin
            log_q.push_back(mk(bus.write, bus.address, bus.write ? bus.writedata : 32'h0));
            if (bus.byteenable !== 4'hF || bus.clken !== 1'b1) proto_bad <= proto_bad + 1;
            if (bus.write) mem[bus.address] <= bus.writedata;
            else bus.readdata <= mem[bus.address] ^ {31'b0, flip[bus.address]};
        end else if (bus.byteenable !== 4'h0 || bus.write !== 1'b0) begin
            proto_bad <= proto_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one operation and compare everything against the reference model.
    task automatic run_op(input logic [1:0] m, input logic [9:0] b, input logic [10:0] wc,
                          input logic [31:0] sd, input int inject_at);
        cyc_t        exp_q [$];
        int          n;
        int          elat;
        bit          epass;
        int          eerr;
        logic [9:0]  efa;
        logic [31:0] efd;
        logic [31:0] es;
        logic [31:0] p;
        logic [31:0] rd;
        logic [9:0]  a;
        int          lat;
        int          busy_cnt;
        int          d0;
        int          pb0;
        int          bad;

        n     = (wc > 11'd1024) ? 1024 : int'(wc);
        es    = (sd == 32'h0) ? 32'h1 : sd;
        eerr  = 0;
        efa   = '0;
        efd   = '0;
        elat  = 1;
        epass = 1'b1;
        if (m == 2'b11) begin
            epass = 1'b0;
        end else if (n != 0) begin
            if (m != 2'b10) begin
                p = es;
                for (int i = 0; i < n; i++) begin
                    a = 10'((int'(b) + i) % DEPTH);
                    exp_q.push_back(mk(1'b1, a, p));
                    ref_mem[a] = p;
                    p = nxt(p);
                end
            end
            if (m != 2'b01) begin
                p = es;
                for (int i = 0; i < n; i++) begin
                    a = 10'((int'(b) + i) % DEPTH);
                    exp_q.push_back(mk(1'b0, a, 32'h0));
                    rd = ref_mem[a] ^ {31'b0, flip[a]};
                    if (rd !== p) begin
                        if (eerr == 0) begin
                            efa = a;
                            efd = rd;
                        end
                        eerr++;
                    end
                    p = nxt(p);
                end
            end
            elat  = (m == 2'b01) ? n + 1 : (m == 2'b10) ? n + 2 : 2 * n + 2;
            epass = (eerr == 0);
        end

        @(negedge clk);
        mode_i    = m;
        base_i    = b;
        wc_i      = wc;
        seed_i    = sd;
        start_i   = 1'b1;
        last_log0 = log_q.size();
        d0        = done_cnt;
        pb0       = proto_bad;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mode_i  = 2'($urandom);
        base_i  = 10'($urandom);
        wc_i    = 11'($urandom);
        seed_i  = $urandom;

        lat      = 0;
        busy_cnt = 0;
        for (int j = 0; j < elat + 6; j++) begin
            if (done_o && lat == 0) lat = j + 1;
            if (busy_o) busy_cnt++;
            start_i = (j == inject_at);
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;

        chk("latency", lat, elat);
        chk("done_pulses", done_cnt - d0, 1);
        chk("busy_cycles", busy_cnt, elat - 1);
        chk("busy_end", busy_o, 1'b0);
        chk("pass", pass_o, epass);
        chk("err_count", err_o, eerr);
        chk("first_err_addr", ferr_addr_o, efa);
        chk("first_err_data", ferr_data_o, efd);
        chk("bus_protocol", proto_bad - pb0, 0);
        chk("bus_len", log_q.size() - last_log0, exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (last_log0 + i < log_q.size() && log_q[last_log0 + i] !== exp_q[i]) bad++;
        chk("bus_seq", bad, 0);
    endtask

    initial begin
        logic [31:0] t2d [4];
        int          t2a [4];
        logic [31:0] w;
        logic [31:0] rseed;
        int          d0;
        int          l0;
        logic [1:0]  rm;
        logic [9:0]  rb;
        logic [10:0] rwc;
        logic [31:0] rsd;
        logic [9:0]  fa;

        start_i = 1'b0;
        mode_i  = 2'b00;
        base_i  = '0;
        wc_i    = '0;
        seed_i  = '0;

        // Reset values
        #12;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_pass", pass_o, 1'b0);
        chk("rst_err", err_o, 11'd0);
        chk("rst_ferr", {ferr_addr_o, ferr_data_o}, 42'd0);
        chk("rst_bus", {bus.chipselect, bus.write, bus.byteenable, bus.address, bus.writedata}, 48'd0);
        chk("rst_clken", bus.clken, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Oversized count clamps to the full memory; also initialises every word
        run_op(2'b01, 10'd37, 11'd2000, 32'h1234_5678, -1);
        chk("clamp_writes", log_q.size() - last_log0, 1024);

        // Clean fill then check
        run_op(2'b00, 10'd0, 11'd4, 32'h1, -1);
        for (int i = 0; i < 4; i++) begin
            w = 32'h1 << i;
            chk("t1_addr", log_q[last_log0 + i].addr, i);
            chk("t1_data", log_q[last_log0 + i].data, w);
        end

        // Address wrap and LFSR feedback
        t2a = '{1022, 1023, 0, 1};
        t2d = '{32'h8000_0000, 32'h0040_0007, 32'h0080_000E, 32'h0100_001C};
        run_op(2'b01, 10'd1022, 11'd4, 32'h8000_0000, -1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", log_q[last_log0 + i].addr, t2a[i]);
            chk("t2_data", log_q[last_log0 + i].data, t2d[i]);
        end

        // Error injection
        flip[5] = 1'b1;
        flip[9] = 1'b1;
        run_op(2'b00, 10'd0, 11'd16, 32'h0, -1);
        chk("t3_data0", log_q[last_log0].data, 32'h1);
        chk("t3_err", err_o, 11'd2);
        chk("t3_faddr", ferr_addr_o, 10'd5);
        chk("t3_fdata", ferr_data_o, 32'h21);
        chk("t3_pass", pass_o, 1'b0);
        flip[5] = 1'b0;
        flip[9] = 1'b0;

        // Zero count and reserved mode
        run_op(2'b00, 10'd200, 11'd0, 32'h5, -1);
        chk("cnt0_pass", pass_o, 1'b1);
        run_op(2'b11, 10'd200, 11'd8, 32'h5, -1);
        chk("mode3_pass", pass_o, 1'b0);

        // Reset during the third write of a fill
        rseed = 32'hCAFE_0001;
        @(negedge clk);
        mode_i  = 2'b01;
        base_i  = 10'd100;
        wc_i    = 11'd10;
        seed_i  = rseed;
        start_i = 1'b1;
        d0      = done_cnt;
        l0      = log_q.size();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_write", {bus.chipselect, bus.write, bus.address}, {1'b1, 1'b1, 10'd102});
        rst = 1'b1;
        #1;
        chk("mid_rst_bus", {bus.chipselect, bus.write, bus.byteenable, bus.address, bus.writedata}, 48'd0);
        chk("mid_rst_stat", {busy_o, done_o, pass_o, err_o, ferr_addr_o, ferr_data_o}, 56'd0);
        chk("mid_rst_clken", bus.clken, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_writes", log_q.size() - l0, 2);
        chk("rst_idle", {busy_o, bus.chipselect}, 2'b00);
        ref_mem[100] = rseed;
        ref_mem[101] = nxt(rseed);

        // Start pulsed during the check pass is ignored
        run_op(2'b00, 10'd500, 11'd8, 32'h0BAD_F00D, 10);

        // Randomised operations, some with injected read errors
        for (int k = 0; k < 10; k++) begin
            rm  = 2'($urandom_range(0, 2));
            rb  = 10'($urandom);
            rwc = 11'($urandom_range(1, 40));
            rsd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            fa  = 10'((int'(rb) + int'($urandom_range(0, int'(rwc) - 1))) % DEPTH);
            if (rm != 2'b01 && $urandom_range(0, 1) == 1) flip[fa] = 1'b1;
            run_op(rm, rb, rwc, rsd, -1);
            flip[fa] = 1'b0;
        end

        // Check-only of a window just filled with a different seed
        run_op(2'b01, 10'd300, 11'd12, 32'h0000_0F0F, -1);
        run_op(2'b10, 10'd300, 11'd12, 32'h0000_0F0F, -1);
        run_op(2'b10, 10'd300, 11'd12, 32'h1357_9BDF, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
